// File: rtl/icache_resp.sv
// icache_resp: direct-mapped instruction cache, responder side of the IFU
// fetch-request interface. Returns one 64-bit aligned line per accepted
// request; hits answer the cycle after acceptance, misses refill through a
// single-beat memory read port.
// Optional build macro ICACHE_PERF_EN adds hit_cnt/miss_cnt counter outputs.
module icache_resp #(
  parameter int NUM_LINES = 64,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cache_req,
  input  logic [ADDR_W-1:0] addr_inst,
  output logic              cache_ready,
  output logic              cache_valid,
  output logic [63:0]       inst_o,
  input  logic              icache_flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [63:0]       mem_rdata
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 3;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    MISS_WAIT,
    REFILL
  } state_t;

  state_t state;
  state_t next_state;

  logic [ADDR_W-1:0]  req_addr;
  logic [IDX_W-1:0]   in_idx;
  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;

  logic [NUM_LINES-1:0] valid_bits;
  logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
  logic [63:0]          data_arr [NUM_LINES];

  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [63:0]        rd_data;
  logic [63:0]        resp_data;
  logic               flush_pending;

  logic hit;
  logic accept;
  logic refill_done;
  logic install;
  logic in_miss;

  // The byte offset never takes part in lookup or refill addressing.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{addr_inst[2:0], req_addr[2:0]};

  assign in_idx      = addr_inst[IDX_W+2:3];
  assign req_idx     = req_addr[IDX_W+2:3];
  assign req_tag     = req_addr[ADDR_W-1:IDX_W+3];
  assign hit         = rd_valid && (rd_tag == req_tag);
  assign accept      = cache_req && cache_ready;
  assign refill_done = (state == MISS_WAIT) && mem_rvalid;
  assign install     = refill_done && !flush_pending && !icache_flush;
  assign in_miss     = (state == MISS_REQ) || (state == MISS_WAIT) || (state == REFILL);
  assign mem_addr    = {req_addr[ADDR_W-1:3], 3'b000};

  // State register; reset abandons any refill in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a hit with a new accept keeps streaming in LOOKUP.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (cache_req) next_state = LOOKUP;
      LOOKUP: begin
        if (!hit)           next_state = MISS_REQ;
        else if (cache_req) next_state = LOOKUP;
        else                next_state = IDLE;
      end
      MISS_REQ:  if (mem_ready)  next_state = MISS_WAIT;
      MISS_WAIT: if (mem_rvalid) next_state = REFILL;
      REFILL:    next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Outputs are a function of state and the registered lookup only.
  always_comb begin
    cache_ready = 1'b0;
    cache_valid = 1'b0;
    inst_o      = '0;
    mem_req     = 1'b0;
    case (state)
      IDLE: cache_ready = 1'b1;
      LOOKUP: begin
        if (hit) begin
          cache_ready = 1'b1;
          cache_valid = 1'b1;
          inst_o      = rd_data;
        end
      end
      MISS_REQ: mem_req = 1'b1;
      REFILL: begin
        cache_valid = 1'b1;
        inst_o      = resp_data;
      end
      default: ;
    endcase
  end

  // Request capture, registered array read, valid bits and flush bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      req_addr      <= '0;
      rd_valid      <= 1'b0;
      rd_tag        <= '0;
      rd_data       <= '0;
      resp_data     <= '0;
      valid_bits    <= '0;
      flush_pending <= 1'b0;
    end else begin
      if (accept) begin
        req_addr <= addr_inst;
        rd_valid <= valid_bits[in_idx] && !icache_flush;
        rd_tag   <= tag_arr[in_idx];
        rd_data  <= data_arr[in_idx];
      end
      if (refill_done) begin
        resp_data <= mem_rdata;
      end
      if (icache_flush) begin
        valid_bits <= '0;
      end else if (install) begin
        valid_bits[req_idx] <= 1'b1;
      end
      if ((next_state == IDLE) && (state != IDLE)) begin
        flush_pending <= 1'b0;
      end else if (icache_flush && in_miss) begin
        flush_pending <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (install) begin
      tag_arr[req_idx]  <= req_tag;
      data_arr[req_idx] <= mem_rdata;
    end
  end

`ifdef ICACHE_PERF_EN
  // Lookup outcome counters, free-running and wrapping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == LOOKUP) begin
      if (hit) hit_cnt  <= hit_cnt + 32'd1;
      else     miss_cnt <= miss_cnt + 32'd1;
    end
  end
`else
  // No performance counters in this build.
`endif

endmodule
